// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
//============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Stall/flush sequencer for the 5-stage pipeline. Handles load-use
//            hazards, taken-branch squashing, and the multi-cycle data memory
//            handshake. Drives write-enable, hold, bubble and flush controls
//            for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// Revision : 1.0  initial release
//============================================================================
module pipeline_hazard_ctrl #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4,
   parameter int PERF_W  = 16
) (
   input  logic              clk,
   input  logic              reset,          // asynchronous, active-low
   input  logic              MemReadEX,
   input  logic [4:0]        WriteRegEX,
   input  logic [4:0]        RsID,
   input  logic [4:0]        RtID,
   input  logic              BranchTakenID,
   input  logic              MemReadMEM,
   input  logic              MemWriteMEM,
   input  logic              mem_ready,
   output logic              mem_req,
   output logic              PCWrite,
   output logic              IFIDWrite,
   output logic              IFIDFlush,
   output logic              IDEXHold,
   output logic              IDEXBubble,
   output logic              EXMEMHold,
   output logic              MEMWBBubble,
   output logic              mem_error,
   output logic [PERF_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);

   state_t              r_state;
   state_t              w_stateNext;
   logic [CNT_W-1:0]    r_waitCnt;
   logic [CNT_W-1:0]    w_waitCntNext;
   logic                r_memError;
   logic                w_memErrorNext;
   logic [PERF_W-1:0]   r_stallCount;

   logic                w_acc;
   logic                w_memStall;
   logic                w_loadUse;

   assign w_acc     = MemReadMEM | MemWriteMEM;
   assign w_loadUse = MemReadEX && (WriteRegEX != 5'd0) &&
                      ((WriteRegEX == RsID) || (WriteRegEX == RtID));

   // State, wait counter, sticky error flag and saturating stall counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_waitCnt    <= '0;
         r_memError   <= 1'b0;
         r_stallCount <= '0;
      end else begin
         r_state    <= w_stateNext;
         r_waitCnt  <= w_waitCntNext;
         r_memError <= w_memErrorNext;
         if (!PCWrite && (r_stallCount != {PERF_W{1'b1}})) begin
            r_stallCount <= r_stallCount + 1'b1;
         end
      end
   end

   // Memory handshake next-state logic and memory-stall detection
   always_comb begin
      w_stateNext    = r_state;
      w_waitCntNext  = r_waitCnt;
      w_memErrorNext = r_memError;
      w_memStall     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_acc && !mem_ready) begin
               w_memStall    = 1'b1;
               w_stateNext   = MEM_WAIT;
               w_waitCntNext = CNT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               w_stateNext   = IDLE;
               w_waitCntNext = '0;
            end else begin
               w_memStall = 1'b1;
               if (r_waitCnt == c_timeout) begin
                  w_stateNext    = ERROR;
                  w_memErrorNext = 1'b1;
               end else begin
                  w_waitCntNext = r_waitCnt + 1'b1;
               end
            end
         end
         ERROR: begin
            w_memStall = 1'b1;
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // Pipeline controls by priority: error/mem stall > load-use > branch > normal;
   // everything forced low while reset is asserted
   always_comb begin
      mem_req     = 1'b0;
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IFIDFlush   = 1'b0;
      IDEXHold    = 1'b0;
      IDEXBubble  = 1'b0;
      EXMEMHold   = 1'b0;
      MEMWBBubble = 1'b0;
      if (reset) begin
         mem_req = ((r_state == IDLE) && w_acc) || (r_state == MEM_WAIT);
         if (w_memStall) begin
            IDEXHold    = 1'b1;
            EXMEMHold   = 1'b1;
            MEMWBBubble = 1'b1;
         end else if (w_loadUse) begin
            IDEXBubble = 1'b1;
         end else begin
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
            IFIDFlush = BranchTakenID;
         end
      end
   end

   assign mem_error   = reset & r_memError;
   assign stall_count = reset ? r_stallCount : '0;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Directed self-checking bench for pipeline_hazard_ctrl.
// Revision : 1.0  initial release
//============================================================================
module tb_pipeline_hazard_ctrl;

   logic        clk;
   logic        reset;
   logic        MemReadEX;
   logic [4:0]  WriteRegEX;
   logic [4:0]  RsID;
   logic [4:0]  RtID;
   logic        BranchTakenID;
   logic        MemReadMEM;
   logic        MemWriteMEM;
   logic        mem_ready;
   logic        mem_req;
   logic        PCWrite;
   logic        IFIDWrite;
   logic        IFIDFlush;
   logic        IDEXHold;
   logic        IDEXBubble;
   logic        EXMEMHold;
   logic        MEMWBBubble;
   logic        mem_error;
   logic [15:0] stall_count;

   int checks   = 0;
   int failures = 0;

   // control vector: {mem_req,PCWrite,IFIDWrite,IFIDFlush,IDEXHold,IDEXBubble,EXMEMHold,MEMWBBubble}
   localparam logic [7:0] ZERO   = 8'b0000_0000;
   localparam logic [7:0] NORMAL = 8'b0110_0000;
   localparam logic [7:0] LU     = 8'b0000_0100;
   localparam logic [7:0] BR     = 8'b0111_0000;
   localparam logic [7:0] MSTALL = 8'b1000_1011;
   localparam logic [7:0] MEMOK  = 8'b1110_0000;
   localparam logic [7:0] ERR    = 8'b0000_1011;

   logic [7:0] ctl;
   assign ctl = {mem_req, PCWrite, IFIDWrite, IFIDFlush,
                 IDEXHold, IDEXBubble, EXMEMHold, MEMWBBubble};

   pipeline_hazard_ctrl #(.TIMEOUT(15), .CNT_W(4), .PERF_W(16)) dut (
      .clk(clk), .reset(reset),
      .MemReadEX(MemReadEX), .WriteRegEX(WriteRegEX), .RsID(RsID), .RtID(RtID),
      .BranchTakenID(BranchTakenID), .MemReadMEM(MemReadMEM),
      .MemWriteMEM(MemWriteMEM), .mem_ready(mem_ready),
      .mem_req(mem_req), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
      .IFIDFlush(IFIDFlush), .IDEXHold(IDEXHold), .IDEXBubble(IDEXBubble),
      .EXMEMHold(EXMEMHold), .MEMWBBubble(MEMWBBubble),
      .mem_error(mem_error), .stall_count(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // apply inputs just after a falling edge
   task automatic drive(input logic mrEx, input logic [4:0] wr, input logic [4:0] rs,
                        input logic [4:0] rt, input logic br, input logic mrMem,
                        input logic mwMem, input logic rdy);
      @(negedge clk);
      MemReadEX = mrEx; WriteRegEX = wr; RsID = rs; RtID = rt;
      BranchTakenID = br; MemReadMEM = mrMem; MemWriteMEM = mwMem; mem_ready = rdy;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("reset_ctl", 32'(ctl), 32'(ZERO));
      chk("reset_stall", 32'(stall_count), 32'd0);
      chk("reset_err", 32'(mem_error), 32'd0);
      tick();
      chk("reset_stall_hold", 32'(stall_count), 32'd0);

      // release reset, quiet cycle
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      chk("normal0", 32'(ctl), 32'(NORMAL));
      tick();

      // load-use on rs
      drive(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lu_rs", 32'(ctl), 32'(LU));
      tick();
      chk("lu_rs_cnt", 32'(stall_count), 32'd1);
      drive(1'b0, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lu_clear", 32'(ctl), 32'(NORMAL));
      tick();

      // r0 never creates a hazard
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lu_r0", 32'(ctl), 32'(NORMAL));
      tick();
      chk("lu_r0_cnt", 32'(stall_count), 32'd1);

      // load-use on rt
      drive(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lu_rt", 32'(ctl), 32'(LU));
      tick();
      chk("lu_rt_cnt", 32'(stall_count), 32'd2);

      // zero-wait store
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("zw_store", 32'(ctl), 32'(MEMOK));
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("zw_idle", 32'(ctl), 32'(NORMAL));
      tick();
      chk("zw_cnt", 32'(stall_count), 32'd2);

      // load with 3 wait cycles, ready on the 4th
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
         chk($sformatf("mw_stall%0d", i), 32'(ctl), 32'(MSTALL));
         tick();
      end
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("mw_release", 32'(ctl), 32'(MEMOK));
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("mw_idle", 32'(ctl), 32'(NORMAL));
      tick();
      chk("mw_cnt", 32'(stall_count), 32'd5);

      // mem stall outranks load-use
      drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("prio_mem_lu", 32'(ctl), 32'(MSTALL));
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("prio_release", 32'(ctl), 32'(MEMOK));
      tick();
      chk("prio_cnt", 32'(stall_count), 32'd6);

      // branch blocked by load-use, flushes next cycle
      drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("br_lu", 32'(ctl), 32'(LU));
      tick();
      drive(1'b0, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("br_flush", 32'(ctl), 32'(BR));
      tick();
      chk("br_cnt", 32'(stall_count), 32'd7);

      // timeout: 16 stalled cycles then ERROR
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
         chk($sformatf("to_stall%0d", i), 32'(ctl), 32'(MSTALL));
         chk($sformatf("to_err%0d", i), 32'(mem_error), 32'd0);
         tick();
      end
      chk("to_err_set", 32'(mem_error), 32'd1);
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
         chk($sformatf("err_ctl%0d", i), 32'(ctl), 32'(ERR));
         tick();
      end
      chk("err_sticky", 32'(mem_error), 32'd1);
      chk("err_cnt", 32'(stall_count), 32'd25);

      // reset clears the trap
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_err_ctl", 32'(ctl), 32'(ZERO));
      chk("rst_err_flag", 32'(mem_error), 32'd0);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      chk("rst_err_normal", 32'(ctl), 32'(NORMAL));

      // reset pulse in MEM_WAIT
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("rmw_stall0", 32'(ctl), 32'(MSTALL));
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("rmw_stall1", 32'(ctl), 32'(MSTALL));
      #1;
      reset = 1'b0;
      #1;
      chk("rmw_ctl", 32'(ctl), 32'(ZERO));
      chk("rmw_cnt", 32'(stall_count), 32'd0);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      chk("rmw_idle", 32'(ctl), 32'(NORMAL));
      tick();
      chk("rmw_cnt_after", 32'(stall_count), 32'd0);
      chk("rmw_err_after", 32'(mem_error), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
